// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter.
//   arb_state_t : arbiter FSM state (idle, icache owns bus, dcache owns bus)
//   owner_t     : identity of the most recent bus owner, used for round-robin
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle   = 2'd0,
      ArbIcache = 2'd1,
      ArbDcache = 2'd2
   } arb_state_t;

   typedef enum logic {
      OwnIcache = 1'b0,
      OwnDcache = 1'b1
   } owner_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of every handshake/data signal between the two caches, the arbiter and the shared bus.
//   modport master : arbiter view (drives grants, bus request side, per-cache response side)
//   modport slave  : environment view (caches + bus, drive requests and bus responses)
interface bus_arbiter_if #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13
);

   // Ownership handshake
   logic                      icache_busreq;
   logic                      icache_busidle;
   logic                      icache_busgrant;
   logic                      dcache_busreq;
   logic                      dcache_busidle;
   logic                      dcache_busgrant;

   // icache transaction side
   logic                      icache_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] icache_req;
   logic [BUS_TAG_WIDTH-1:0]  icache_reqtag;
   logic                      icache_respack;
   logic                      icache_reqack;
   logic                      icache_respcyc;
   logic [BUS_DATA_WIDTH-1:0] icache_resp;
   logic [BUS_TAG_WIDTH-1:0]  icache_resptag;

   // dcache transaction side
   logic                      dcache_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] dcache_req;
   logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag;
   logic                      dcache_respack;
   logic                      dcache_reqack;
   logic                      dcache_respcyc;
   logic [BUS_DATA_WIDTH-1:0] dcache_resp;
   logic [BUS_TAG_WIDTH-1:0]  dcache_resptag;

   // Shared bus side
   logic                      bus_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] bus_req;
   logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
   logic                      bus_respack;
   logic                      bus_reqack;
   logic                      bus_respcyc;
   logic [BUS_DATA_WIDTH-1:0] bus_resp;
   logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

   modport master (
      input  icache_busreq, icache_busidle, dcache_busreq, dcache_busidle,
      input  icache_reqcyc, icache_req, icache_reqtag, icache_respack,
      input  dcache_reqcyc, dcache_req, dcache_reqtag, dcache_respack,
      input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      output icache_busgrant, dcache_busgrant,
      output icache_reqack, icache_respcyc, icache_resp, icache_resptag,
      output dcache_reqack, dcache_respcyc, dcache_resp, dcache_resptag,
      output bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );

   modport slave (
      output icache_busreq, icache_busidle, dcache_busreq, dcache_busidle,
      output icache_reqcyc, icache_req, icache_reqtag, icache_respack,
      output dcache_reqcyc, dcache_req, dcache_reqtag, dcache_respack,
      output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      input  icache_busgrant, dcache_busgrant,
      input  icache_reqack, icache_respcyc, icache_resp, icache_resptag,
      input  dcache_reqack, dcache_respcyc, dcache_resp, dcache_resptag,
      input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );

endinterface

// File: rtl/bus_arbiter_mux.sv
// Combinational owner routing for the bus arbiter.
//   state_i         : current arbiter state; selects which cache drives the bus
//   ic_* / dc_*     : per-cache request inputs and gated response outputs
//   bus_*           : shared-bus request outputs and response inputs
// Responses data/tag are broadcast; only the cycle/ack strobes are gated to the owner.
module bus_arbiter_mux
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13
) (
   input  arb_state_t                state_i,

   input  logic                      ic_reqcyc_i,
   input  logic [BUS_DATA_WIDTH-1:0] ic_req_i,
   input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag_i,
   input  logic                      ic_respack_i,
   output logic                      ic_reqack_o,
   output logic                      ic_respcyc_o,
   output logic [BUS_DATA_WIDTH-1:0] ic_resp_o,
   output logic [BUS_TAG_WIDTH-1:0]  ic_resptag_o,

   input  logic                      dc_reqcyc_i,
   input  logic [BUS_DATA_WIDTH-1:0] dc_req_i,
   input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag_i,
   input  logic                      dc_respack_i,
   output logic                      dc_reqack_o,
   output logic                      dc_respcyc_o,
   output logic [BUS_DATA_WIDTH-1:0] dc_resp_o,
   output logic [BUS_TAG_WIDTH-1:0]  dc_resptag_o,

   output logic                      bus_reqcyc_o,
   output logic [BUS_DATA_WIDTH-1:0] bus_req_o,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_o,
   output logic                      bus_respack_o,
   input  logic                      bus_reqack_i,
   input  logic                      bus_respcyc_i,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp_i,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag_i
);

   assign ic_resp_o    = bus_resp_i;
   assign ic_resptag_o = bus_resptag_i;
   assign dc_resp_o    = bus_resp_i;
   assign dc_resptag_o = bus_resptag_i;

   always_comb begin
      bus_reqcyc_o  = 1'b0;
      bus_req_o     = '0;
      bus_reqtag_o  = '0;
      bus_respack_o = 1'b0;
      ic_reqack_o   = 1'b0;
      ic_respcyc_o  = 1'b0;
      dc_reqack_o   = 1'b0;
      dc_respcyc_o  = 1'b0;
      unique case (state_i)
         ArbIcache: begin
            bus_reqcyc_o  = ic_reqcyc_i;
            bus_req_o     = ic_req_i;
            bus_reqtag_o  = ic_reqtag_i;
            bus_respack_o = ic_respack_i;
            ic_reqack_o   = bus_reqack_i;
            ic_respcyc_o  = bus_respcyc_i;
         end
         ArbDcache: begin
            bus_reqcyc_o  = dc_reqcyc_i;
            bus_req_o     = dc_req_i;
            bus_reqtag_o  = dc_reqtag_i;
            bus_respack_o = dc_respack_i;
            dc_reqack_o   = bus_reqack_i;
            dc_respcyc_o  = bus_respcyc_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (icache/dcache) bus arbiter with round-robin tie-break and no preemption.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; forces idle and last owner = icache
//   bif   : all handshake, request, response and bus signals (master modport)
// An owner keeps the bus while it requests or has a transaction outstanding; every handover
// passes through at least one idle cycle.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_if.master bif
);

   arb_state_t state_q, state_d;
   owner_t     last_owner_q, last_owner_d;

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      unique case (state_q)
         ArbIdle: begin
            if (bif.icache_busreq && bif.dcache_busreq) begin
               // Tie goes to whoever did not own the bus last.
               state_d = (last_owner_q == OwnIcache) ? ArbDcache : ArbIcache;
            end else if (bif.icache_busreq) begin
               state_d = ArbIcache;
            end else if (bif.dcache_busreq) begin
               state_d = ArbDcache;
            end
            if (state_d == ArbIcache) last_owner_d = OwnIcache;
            if (state_d == ArbDcache) last_owner_d = OwnDcache;
         end
         ArbIcache: begin
            if (!bif.icache_busreq && bif.icache_busidle) state_d = ArbIdle;
         end
         ArbDcache: begin
            if (!bif.dcache_busreq && bif.dcache_busidle) state_d = ArbIdle;
         end
         default: state_d = ArbIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ArbIdle;
         last_owner_q <= OwnIcache;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
      end
   end

   assign bif.icache_busgrant = (state_q == ArbIcache);
   assign bif.dcache_busgrant = (state_q == ArbDcache);

   bus_arbiter_mux #(
      .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
      .BUS_TAG_WIDTH (BUS_TAG_WIDTH)
   ) u_mux (
      .state_i      (state_q),
      .ic_reqcyc_i  (bif.icache_reqcyc),
      .ic_req_i     (bif.icache_req),
      .ic_reqtag_i  (bif.icache_reqtag),
      .ic_respack_i (bif.icache_respack),
      .ic_reqack_o  (bif.icache_reqack),
      .ic_respcyc_o (bif.icache_respcyc),
      .ic_resp_o    (bif.icache_resp),
      .ic_resptag_o (bif.icache_resptag),
      .dc_reqcyc_i  (bif.dcache_reqcyc),
      .dc_req_i     (bif.dcache_req),
      .dc_reqtag_i  (bif.dcache_reqtag),
      .dc_respack_i (bif.dcache_respack),
      .dc_reqack_o  (bif.dcache_reqack),
      .dc_respcyc_o (bif.dcache_respcyc),
      .dc_resp_o    (bif.dcache_resp),
      .dc_resptag_o (bif.dcache_resptag),
      .bus_reqcyc_o (bif.bus_reqcyc),
      .bus_req_o    (bif.bus_req),
      .bus_reqtag_o (bif.bus_reqtag),
      .bus_respack_o(bif.bus_respack),
      .bus_reqack_i (bif.bus_reqack),
      .bus_respcyc_i(bif.bus_respcyc),
      .bus_resp_i   (bif.bus_resp),
      .bus_resptag_i(bif.bus_resptag)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by randomized traffic with
// occasional asynchronous resets, all compared against a behavioural owner model.
module tb_bus_arbiter;

   localparam int unsigned DW = 64;
   localparam int unsigned TW = 13;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   // Model: owner 0 = nobody, 1 = icache, 2 = dcache; m_last is the most recent owner.
   int   m_owner;
   int   m_last;

   bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

   bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
      .clk  (clk),
      .reset(reset),
      .bif  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t owner=%0d)", tag, got, exp, $time,
                  m_owner);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_last  = 1;
   endtask

   // Advance the model by one clock edge from the currently applied inputs.
   task automatic model_edge();
      if (!reset) begin
         model_reset();
      end else if (m_owner == 0) begin
         if (bif.icache_busreq && bif.dcache_busreq) m_owner = (m_last == 1) ? 2 : 1;
         else if (bif.icache_busreq) m_owner = 1;
         else if (bif.dcache_busreq) m_owner = 2;
         if (m_owner != 0) m_last = m_owner;
      end else if (m_owner == 1) begin
         if (!bif.icache_busreq && bif.icache_busidle) m_owner = 0;
      end else begin
         if (!bif.dcache_busreq && bif.dcache_busidle) m_owner = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_all();
      logic        e_reqcyc, e_respack, e_ic_ack, e_ic_rc, e_dc_ack, e_dc_rc;
      logic [63:0] e_req;
      logic [63:0] e_tag;
      e_reqcyc = 1'b0; e_respack = 1'b0; e_req = '0; e_tag = '0;
      e_ic_ack = 1'b0; e_ic_rc = 1'b0; e_dc_ack = 1'b0; e_dc_rc = 1'b0;
      if (m_owner == 1) begin
         e_reqcyc = bif.icache_reqcyc;  e_req = bif.icache_req;
         e_tag = 64'(bif.icache_reqtag); e_respack = bif.icache_respack;
         e_ic_ack = bif.bus_reqack;      e_ic_rc = bif.bus_respcyc;
      end else if (m_owner == 2) begin
         e_reqcyc = bif.dcache_reqcyc;  e_req = bif.dcache_req;
         e_tag = 64'(bif.dcache_reqtag); e_respack = bif.dcache_respack;
         e_dc_ack = bif.bus_reqack;      e_dc_rc = bif.bus_respcyc;
      end
      check_eq("icache_busgrant", 64'(bif.icache_busgrant), 64'(m_owner == 1));
      check_eq("dcache_busgrant", 64'(bif.dcache_busgrant), 64'(m_owner == 2));
      check_eq("bus_reqcyc", 64'(bif.bus_reqcyc), 64'(e_reqcyc));
      check_eq("bus_req", bif.bus_req, e_req);
      check_eq("bus_reqtag", 64'(bif.bus_reqtag), e_tag);
      check_eq("bus_respack", 64'(bif.bus_respack), 64'(e_respack));
      check_eq("icache_reqack", 64'(bif.icache_reqack), 64'(e_ic_ack));
      check_eq("icache_respcyc", 64'(bif.icache_respcyc), 64'(e_ic_rc));
      check_eq("dcache_reqack", 64'(bif.dcache_reqack), 64'(e_dc_ack));
      check_eq("dcache_respcyc", 64'(bif.dcache_respcyc), 64'(e_dc_rc));
      check_eq("icache_resp", bif.icache_resp, bif.bus_resp);
      check_eq("dcache_resp", bif.dcache_resp, bif.bus_resp);
      check_eq("icache_resptag", 64'(bif.icache_resptag), 64'(bif.bus_resptag));
      check_eq("dcache_resptag", 64'(bif.dcache_resptag), 64'(bif.bus_resptag));
   endtask

   task automatic clear_inputs();
      bif.icache_busreq = 1'b0; bif.icache_busidle = 1'b1;
      bif.dcache_busreq = 1'b0; bif.dcache_busidle = 1'b1;
      bif.icache_reqcyc = 1'b0; bif.icache_req = '0; bif.icache_reqtag = '0;
      bif.icache_respack = 1'b0;
      bif.dcache_reqcyc = 1'b0; bif.dcache_req = '0; bif.dcache_reqtag = '0;
      bif.dcache_respack = 1'b0;
      bif.bus_reqack = 1'b0; bif.bus_respcyc = 1'b0; bif.bus_resp = '0; bif.bus_resptag = '0;
   endtask

   task automatic randomize_inputs();
      bif.icache_busreq  = ($urandom_range(0, 99) < 45);
      bif.dcache_busreq  = ($urandom_range(0, 99) < 45);
      bif.icache_busidle = ($urandom_range(0, 99) < 65);
      bif.dcache_busidle = ($urandom_range(0, 99) < 65);
      bif.icache_reqcyc  = 1'($urandom);
      bif.icache_req     = {$urandom, $urandom};
      bif.icache_reqtag  = TW'($urandom);
      bif.icache_respack = 1'($urandom);
      bif.dcache_reqcyc  = 1'($urandom);
      bif.dcache_req     = {$urandom, $urandom};
      bif.dcache_reqtag  = TW'($urandom);
      bif.dcache_respack = 1'($urandom);
      bif.bus_reqack     = 1'($urandom);
      bif.bus_respcyc    = 1'($urandom);
      bif.bus_resp       = {$urandom, $urandom};
      bif.bus_resptag    = TW'($urandom);
   endtask

   // Pulse reset between edges and check the immediate effect.
   task automatic async_reset_pulse();
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      check_eq("rst_icache_grant", 64'(bif.icache_busgrant), 64'd0);
      check_eq("rst_dcache_grant", 64'(bif.dcache_busgrant), 64'd0);
      reset = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      clear_inputs();

      // Reset with icache driving a request cycle: bus must stay quiet.
      reset = 1'b0;
      bif.icache_reqcyc = 1'b1;
      bif.icache_busreq = 1'b1;
      bif.icache_req    = 64'h1234;
      tick();
      tick();
      check_all();
      check_eq("reset_bus_reqcyc", 64'(bif.bus_reqcyc), 64'd0);
      check_eq("reset_bus_req", bif.bus_req, 64'd0);
      check_eq("reset_grant", 64'({bif.icache_busgrant, bif.dcache_busgrant}), 64'd0);
      reset = 1'b1;
      clear_inputs();
      #1;

      // Single icache request: grant one edge later, data routed, dcache ack gated.
      bif.icache_busreq = 1'b1;
      #1 check_eq("single_pre_grant", 64'(bif.icache_busgrant), 64'd0);
      tick();
      bif.icache_req = 64'h1000;
      bif.bus_reqack = 1'b1;
      #1;
      check_all();
      check_eq("single_grant", 64'(bif.icache_busgrant), 64'd1);
      check_eq("single_bus_req", bif.bus_req, 64'h1000);
      check_eq("single_dc_reqack", 64'(bif.dcache_reqack), 64'd0);
      check_eq("single_ic_reqack", 64'(bif.icache_reqack), 64'd1);

      // Response gating while icache owns.
      bif.bus_respcyc = 1'b1;
      bif.bus_resp    = 64'hDEAD_BEEF;
      bif.bus_resptag = 13'h5;
      #1;
      check_eq("resp_ic_respcyc", 64'(bif.icache_respcyc), 64'd1);
      check_eq("resp_dc_respcyc", 64'(bif.dcache_respcyc), 64'd0);
      check_eq("resp_ic_resp", bif.icache_resp, 64'hDEAD_BEEF);
      check_eq("resp_dc_resp", bif.dcache_resp, 64'hDEAD_BEEF);
      check_eq("resp_dc_tag", 64'(bif.dcache_resptag), 64'h5);

      // No early release: busidle low keeps the grant.
      bif.icache_busreq  = 1'b0;
      bif.icache_busidle = 1'b0;
      tick();
      check_eq("hold_grant_1", 64'(bif.icache_busgrant), 64'd1);
      tick();
      check_eq("hold_grant_2", 64'(bif.icache_busgrant), 64'd1);
      bif.icache_busidle = 1'b1;
      #1 check_eq("hold_grant_3", 64'(bif.icache_busgrant), 64'd1);
      tick();
      check_eq("release_grant", 64'(bif.icache_busgrant), 64'd0);
      check_all();

      // Simultaneous requests after reset: dcache first, then icache after one idle cycle.
      async_reset_pulse();
      clear_inputs();
      bif.icache_busreq = 1'b1;
      bif.dcache_busreq = 1'b1;
      tick();
      check_eq("tie_dcache_grant", 64'(bif.dcache_busgrant), 64'd1);
      check_eq("tie_icache_grant", 64'(bif.icache_busgrant), 64'd0);
      bif.dcache_busreq = 1'b0;
      tick();
      check_eq("rr_idle_ic", 64'(bif.icache_busgrant), 64'd0);
      check_eq("rr_idle_dc", 64'(bif.dcache_busgrant), 64'd0);
      tick();
      check_eq("rr_icache_grant", 64'(bif.icache_busgrant), 64'd1);
      check_eq("rr_dcache_grant", 64'(bif.dcache_busgrant), 64'd0);
      check_all();

      // Randomized traffic with rare mid-transaction resets.
      for (int i = 0; i < 1500; i++) begin
         tick();
         randomize_inputs();
         if ($urandom_range(0, 63) == 0) begin
            async_reset_pulse();
         end else begin
            #1;
            check_all();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, width of request/response data.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, width of request/response tags.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 icache_busreq, dcache_busreq  in  1 each  requester wants the bus.
REQ-007 icache_busidle, dcache_busidle  in  1 each  requester has no transaction outstanding.
REQ-008 icache_busgrant, dcache_busgrant  out  1 each  requester owns the bus.
REQ-009 Per-requester request side, X in {icache, dcache}: X_reqcyc in 1, X_req in BUS_DATA_WIDTH, X_reqtag in BUS_TAG_WIDTH, X_respack in 1.
REQ-010 Per-requester response side, X in {icache, dcache}: X_reqack out 1, X_respcyc out 1, X_resp out BUS_DATA_WIDTH, X_resptag out BUS_TAG_WIDTH.
REQ-011 Bus outputs: bus_reqcyc 1, bus_req BUS_DATA_WIDTH, bus_reqtag BUS_TAG_WIDTH, bus_respack 1.
REQ-012 Bus inputs: bus_reqack 1, bus_respcyc 1, bus_resp BUS_DATA_WIDTH, bus_resptag BUS_TAG_WIDTH.

Function
REQ-013 FSM states: IDLE, ICACHE (icache owns), DCACHE (dcache owns).
REQ-014 icache_busgrant SHALL be 1 iff state is ICACHE; dcache_busgrant SHALL be 1 iff state is DCACHE; grants are never both 1.
REQ-015 IDLE, only one busreq high: go to that owner's state on the next edge, so grant rises one cycle after the request is sampled.
REQ-016 IDLE, both requests high: grant the requester that was not the most recent owner (round-robin), tracked by a last_owner register.
REQ-017 IDLE, no request: stay in IDLE.
REQ-018 Owner state: stay while owner busreq=1 or owner busidle=0.
REQ-019 Owner state: return to IDLE on the edge where owner busreq=0 and busidle=1.
REQ-020 Handover: at least one IDLE cycle between owners; direct owner-to-owner transition is not allowed.
REQ-021 Requests from the non-owner SHALL be ignored until IDLE; no preemption.
REQ-022 Owner routing, combinational: bus_reqcyc, bus_req, bus_reqtag and bus_respack = owner's X_reqcyc, X_req, X_reqtag and X_respack.
REQ-023 Owner routing, combinational: owner's X_reqack = bus_reqack and owner's X_respcyc = bus_respcyc.
REQ-024 Non-owner's X_reqack and X_respcyc SHALL be 0.
REQ-025 bus_resp and bus_resptag SHALL be broadcast to both X_resp and X_resptag regardless of owner.
REQ-026 In IDLE: bus_reqcyc, bus_respack, bus_req and bus_reqtag SHALL be 0, and both X_reqack and X_respcyc SHALL be 0.
REQ-027 last_owner SHALL update on entry to ICACHE or DCACHE.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE and both grants 0, and bus outputs SHALL follow the IDLE values of REQ-026.
REQ-029 reset=0 SHALL set last_owner=ICACHE, so dcache wins the first simultaneous request.
REQ-030 Reset mid-transaction SHALL abandon ownership without waiting for busidle; the first grant after release follows REQ-015/016.

Structure
REQ-031 A shared package SHALL hold the arb_state_t enum (IDLE, ICACHE, DCACHE) and the owner_t enum (ICACHE, DCACHE).
REQ-032 Width parameters SHALL remain module parameters.
REQ-033 One combinational sub-module, bus_arbiter_mux (owner routing and gating of REQ-022..026), is natural; the FSM SHALL stay in bus_arbiter.
REQ-034 Target size: 120-400 lines of RTL total.

Verification
REQ-035 Reset: reset=0 with icache_reqcyc=1 -> both grants 0, bus_reqcyc=0, bus_req=0.
REQ-036 Single request: icache_busreq=1 at cycle 0 -> icache_busgrant=1 at cycle 1; icache_req=64'h1000 appears on bus_req the same cycle; dcache_reqack=0 while bus_reqack=1.
REQ-037 Simultaneous requests after reset -> dcache granted first.
REQ-038 Round-robin: after dcache releases (busreq=0, busidle=1) -> one IDLE cycle, then icache granted; dcache_busgrant=0 throughout.
REQ-039 No early release: owner busreq=0 with busidle=0 -> grant held until busidle=1, then dropped on the next edge.
REQ-040 Response gating: bus_respcyc=1, bus_resp=64'hDEAD_BEEF, bus_resptag=13'h5 with icache owning -> icache_respcyc=1, dcache_respcyc=0, both X_resp = 64'hDEAD_BEEF.
